// File: rtl/mips_result_trace.sv
// -----------------------------------------------------------------------------
// mips_result_trace
//
// Debug capture buffer placed downstream of the processor top. On every enabled
// cycle the execute-stage ALUResult / MemStageWriteData pair is stamped with a
// free-running 16-bit cycle count and pushed as an 80-bit entry into a FIFO.
// A host-side consumer drains the FIFO through a show-ahead valid/ready port.
// Samples that arrive while the FIFO is full are dropped. Each drop sets a
// sticky overflow flag and increments a saturating drop counter.
//
// Configuration macro:
//   TRACE_CHANGE_ONLY_EN  when defined, a sample is pushed only if its
//                         {MemStageWriteData, ALUResult} pair differs from
//                         the previously sampled pair.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, 2..256)
//   CW     width of count, $clog2(DEPTH)+1 (derived)
//
// Ports:
//   clk                in   rising-edge clock
//   rst                in   synchronous active-high reset
//   ALUResult          in   [31:0] execute-stage ALU result
//   MemStageWriteData  in   [31:0] execute-stage store data
//   capture_en         in   sample the inputs this cycle
//   out_valid          out  FIFO non-empty
//   out_ready          in   consumer accepts the head entry
//   out_data           out  [79:0] {stamp, MemStageWriteData, ALUResult} of head
//   count              out  [CW-1:0] occupancy, 0..DEPTH
//   overflow           out  sticky: at least one sample dropped
//   drop_cnt           out  [15:0] dropped samples, saturating at 16'hFFFF
//   clr_ovf            in   clear overflow and drop_cnt
// -----------------------------------------------------------------------------
module mips_result_trace #(
  parameter int  DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   ALUResult,
  input  logic [31:0]   MemStageWriteData,
  input  logic          capture_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [79:0]   out_data,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [15:0]   drop_cnt,
  input  logic          clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [79:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] countQ;
  logic [15:0]   stamp;
  logic          overflowQ;
  logic [15:0]   dropCntQ;

  logic          pushReq;
  logic          pushAcc;
  logic          popEn;
  logic          full;
  logic          dropEn;

  // ---------------------------------------------------------------------------
  // Push request, optionally filtered to changed samples only
  // ---------------------------------------------------------------------------
`ifdef TRACE_CHANGE_ONLY_EN
  logic [63:0] lastPair;
  logic        lastValid;

  // The last-sampled pair tracks every capture_en cycle, dropped or not, so the
  // filter compares against what the processor produced, not what was stored.
  // lastValid forces the first enabled sample after reset to push.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastValid <= 1'b0;
    end else if (capture_en) begin
      lastPair  <= {MemStageWriteData, ALUResult};
      lastValid <= 1'b1;
    end
  end

  assign pushReq = capture_en &&
                   (!lastValid || ({MemStageWriteData, ALUResult} != lastPair));
`else
  assign pushReq = capture_en;
`endif

  // ---------------------------------------------------------------------------
  // Handshake decode. out_valid depends only on registered occupancy, so there
  // is no combinational path from out_ready back to out_valid / out_data.
  // ---------------------------------------------------------------------------
  assign full      = (countQ == CW'(DEPTH));
  assign out_valid = (countQ != '0);
  assign popEn     = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pushAcc   = pushReq && (!full || popEn);
  assign dropEn    = pushReq && full && !popEn;

  assign out_data  = mem[rdPtr];
  assign count     = countQ;
  assign overflow  = overflowQ;
  assign drop_cnt  = dropCntQ;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; out_valid gates its contents, and
  // leaving it unreset lets it map onto RAM/LUT-RAM without a clear path.
  always_ff @(posedge clk) begin
    if (pushAcc && !rst) begin
      mem[wrPtr] <= {stamp, MemStageWriteData, ALUResult};
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and stamp
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
      stamp  <= '0;
    end else begin
      stamp <= stamp + 16'd1;
      // AW-bit pointers wrap modulo DEPTH because DEPTH is a power of two.
      if (pushAcc) wrPtr <= wrPtr + AW'(1);
      if (popEn)   rdPtr <= rdPtr + AW'(1);
      case ({pushAcc, popEn})
        2'b10:   countQ <= countQ + CW'(1);
        2'b01:   countQ <= countQ - CW'(1);
        default: countQ <= countQ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow tracking. A clear wins over a same-cycle drop, and that drop is
  // not counted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      overflowQ <= 1'b0;
      dropCntQ  <= '0;
    end else if (clr_ovf) begin
      overflowQ <= 1'b0;
      dropCntQ  <= '0;
    end else if (dropEn) begin
      overflowQ <= 1'b1;
      if (dropCntQ != 16'hFFFF) dropCntQ <= dropCntQ + 16'd1;
    end
  end

endmodule

// File: tb/tb_mips_result_trace.sv
// -----------------------------------------------------------------------------
// tb_mips_result_trace
//
// Self-checking bench for mips_result_trace (DEPTH=16). A queue-based reference
// model tracks the expected FIFO contents, stamp, overflow flag and drop count
// from the behavioural rules; each test task compares DUT outputs inline.
// Define TRACE_CHANGE_ONLY_EN for both files to exercise the change-only build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_result_trace;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [31:0]   ALUResult;
  logic [31:0]   MemStageWriteData;
  logic          capture_en;
  logic          out_valid;
  logic          out_ready;
  logic [79:0]   out_data;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   drop_cnt;
  logic          clr_ovf;

  int errors = 0;
  int checks = 0;

  mips_result_trace #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .ALUResult         (ALUResult),
    .MemStageWriteData (MemStageWriteData),
    .capture_en        (capture_en),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .count             (count),
    .overflow          (overflow),
    .drop_cnt          (drop_cnt),
    .clr_ovf           (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [79:0] m_q[$];
  int          m_stamp;
  bit          m_ovf;
  int          m_drop;
  logic [63:0] m_last;
  bit          m_last_valid;

  task automatic model_edge(input logic r, input logic cap, input logic [31:0] a,
                            input logic [31:0] m, input logic rdy, input logic clr);
    bit pop, req, accept, dropped;
    if (r) begin
      m_q.delete();
      m_stamp = 0; m_ovf = 0; m_drop = 0; m_last_valid = 0;
      return;
    end
    pop = (m_q.size() > 0) && rdy;
    req = cap;
`ifdef TRACE_CHANGE_ONLY_EN
    req = cap && (!m_last_valid || ({m, a} != m_last));
    if (cap) begin
      m_last = {m, a};
      m_last_valid = 1;
    end
`endif
    accept  = req && ((m_q.size() < DEPTH) || pop);
    dropped = req && !accept;
    if (pop) void'(m_q.pop_front());
    if (accept) m_q.push_back({16'(m_stamp), m, a});
    if (clr) begin
      m_ovf = 0; m_drop = 0;
    end else if (dropped) begin
      m_ovf = 1;
      if (m_drop < 65535) m_drop++;
    end
    m_stamp = (m_stamp + 1) % 65536;
  endtask

  // Drive one cycle: inputs change 1ns after the edge, outputs are read 1ns
  // after the next edge.
  task automatic tick(input logic r, input logic cap, input logic [31:0] a,
                      input logic [31:0] m, input logic rdy, input logic clr);
    rst = r; capture_en = cap; ALUResult = a; MemStageWriteData = m;
    out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    model_edge(r, cap, a, m, rdy, clr);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt: got %h expected 0000", drop_cnt); end
  endtask

  task automatic test_basic();
    logic [79:0] exp;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 32'(i + 1), 32'hA0 + 32'(i), 1'b0, 1'b0);
    checks++; if (count !== CW'(3)) begin errors++; $display("FAIL basic_count: got %0d expected 3", count); end
    for (int i = 0; i < 3; i++) begin
      exp = {16'(i), 32'hA0 + 32'(i), 32'(i + 1)};
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++; $display("FAIL basic_head%0d: got v=%b %h expected v=1 %h", i, out_valid, out_data, exp);
      end
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    checks++; if (out_valid !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL basic_empty: got v=%b count=%0d expected v=0 count=0", out_valid, count);
    end
  endtask

  task automatic test_overflow();
    logic [79:0] exp;
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 32'(i), ~32'(i), 1'b0, 1'b0);
    checks++; if (count !== CW'(16)) begin errors++; $display("FAIL ovf_count: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL ovf_drop4: got %0d expected 4", drop_cnt); end
    // Clear in a dropping cycle: clear wins, drop not counted.
    tick(1'b0, 1'b1, 32'd200, 32'd200, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL ovf_clear: got ovf=%b drop=%0d expected ovf=0 drop=0", overflow, drop_cnt);
    end
    tick(1'b0, 1'b1, 32'd201, 32'd201, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin
      errors++; $display("FAIL ovf_redrop: got ovf=%b drop=%0d expected ovf=1 drop=1", overflow, drop_cnt);
    end
    // Drain: the first 16 samples in order, stamps 0..15.
    for (int i = 0; i < 16; i++) begin
      exp = {16'(i), ~32'(i), 32'(i)};
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++; $display("FAIL ovf_drain%0d: got v=%b %h expected v=1 %h", i, out_valid, out_data, exp);
      end
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    checks++; if (count !== '0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 32'd100 + 32'(i), 32'h5000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 32'd300 + 32'(i), 32'h6000 + 32'(i), 1'b1, 1'b0);
      checks++; if (count !== CW'(16) || drop_cnt !== 16'd1) begin
        errors++; $display("FAIL b2b_level%0d: got count=%0d drop=%0d expected count=16 drop=1", i, count, drop_cnt);
      end
      checks++; if (out_data !== m_q[0]) begin
        errors++; $display("FAIL b2b_head%0d: got %h expected %h", i, out_data, m_q[0]);
      end
    end
    // The tenth pop leaves sample 110 at the head.
    checks++; if (out_data[31:0] !== 32'd110) begin
      errors++; $display("FAIL b2b_order: got %0d expected 110", out_data[31:0]);
    end
  endtask

  task automatic test_random();
    logic cap, rdy, clr;
    logic [31:0] a, m;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cap = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 31) == 0);
      a   = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 2)) : $urandom;
      m   = ($urandom_range(0, 1) != 0) ? 32'h0 : $urandom;
      tick(1'b0, cap, a, m, rdy, clr);
      checks++; if (out_valid !== (m_q.size() > 0) || count !== CW'(m_q.size())) begin
        errors++; $display("FAIL rand_level%0d: got v=%b count=%0d expected count=%0d", i, out_valid, count, m_q.size());
      end
      checks++; if (overflow !== m_ovf || drop_cnt !== 16'(m_drop)) begin
        errors++; $display("FAIL rand_ovf%0d: got ovf=%b drop=%0d expected ovf=%b drop=%0d", i, overflow, drop_cnt, m_ovf, m_drop);
      end
      if (m_q.size() > 0) begin
        checks++; if (out_data !== m_q[0]) begin
          errors++; $display("FAIL rand_head%0d: got %h expected %h", i, out_data, m_q[0]);
        end
      end
    end
  endtask

  task automatic test_stamp_wrap();
    logic [79:0] exp;
    do_reset();
    for (int i = 0; i < 65534; i++) idle();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 32'h77 + 32'(i), 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp = {16'hFFFE + 16'(i), 32'h0, 32'h77 + 32'(i)};
      checks++; if (out_data !== exp) begin
        errors++; $display("FAIL wrap_stamp%0d: got %h expected %h", i, out_data, exp);
      end
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    // Mid-operation reset with seven entries queued.
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 32'h900 + 32'(i), 32'h1, 1'b0, 1'b0);
    checks++; if (count !== CW'(7)) begin errors++; $display("FAIL midrst_pre: got %0d expected 7", count); end
    tick(1'b1, 1'b1, 32'h999, 32'h2, 1'b1, 1'b0);
    checks++; if (count !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_post: got count=%0d v=%b expected count=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_change_only();
    int alu_seq [6] = '{5, 5, 5, 6, 6, 5};
`ifdef TRACE_CHANGE_ONLY_EN
    int exp_n = 3;
    int exp_alu [6] = '{5, 6, 5, 0, 0, 0};
    int exp_stp [6] = '{0, 3, 5, 0, 0, 0};
`else
    int exp_n = 6;
    int exp_alu [6] = '{5, 5, 5, 6, 6, 5};
    int exp_stp [6] = '{0, 1, 2, 3, 4, 5};
`endif
    logic [79:0] exp;
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 32'(alu_seq[i]), 32'h0, 1'b0, 1'b0);
    checks++; if (count !== CW'(exp_n)) begin
      errors++; $display("FAIL chg_count: got %0d expected %0d", count, exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      exp = {16'(exp_stp[i]), 32'h0, 32'(exp_alu[i])};
      checks++; if (out_data !== exp) begin
        errors++; $display("FAIL chg_entry%0d: got %h expected %h", i, out_data, exp);
      end
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; capture_en = 1'b0; ALUResult = '0; MemStageWriteData = '0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_random();
    test_change_only();
    test_stamp_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
